rs485_uart_tx: RTL and testbench
================================

# rs485_uart_tx

Byte-serial RS485 transmitter: accepts one byte per `tx_en` strobe from the command-echo controller, serialises it as UART 8N1 (LSB first) on `rs485_txd`, and drives the half-duplex transceiver enable `rs485_de` with programmable setup and hold guard times. It sits directly downstream of the controller/RAM read port. `tx_busy` is the controller's back-pressure signal: low means a new byte may be issued.

## Interface
- `CLK_FREQ`, 50_000_000: clk frequency in Hz.
- `BAUD`, 115200: line rate; `BIT_CYCLES = CLK_FREQ/BAUD` (integer division, truncating), must be ≥ 2 and < 65536.
- `DE_SETUP_CYCLES`, 16: clocks `rs485_de` is high before the start bit; ≥ 1.
- `DE_HOLD_CYCLES`, 16: clocks `rs485_de` stays high after the stop bit ends; ≥ 1.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `tx_en`  in  1  single-cycle strobe; `tx_data` is valid in the same cycle.
- `tx_data`  in  8  byte to send (RAM read data).
- `tx_busy`  out  1  high while a frame is in progress; low = ready to accept `tx_en`.
- `tx_done`  out  1  one-cycle pulse on the last clock of the stop bit.
- `rs485_txd`  out  1  serial line, idle high.
- `rs485_de`  out  1  transceiver driver enable, active high.

## Operation
- Reset values: `rs485_txd`=1, `rs485_de`=0, `tx_busy`=0, `tx_done`=0, FSM=IDLE, all counters 0.
- FSM states: IDLE, SETUP, START, DATA, [PARITY], STOP, HOLD.
- IDLE: on `tx_en`, latch `tx_data` into the shift register, set `tx_busy`=1 and `rs485_de`=1, then go to SETUP.
- SETUP: count `DE_SETUP_CYCLES` clocks, then go to START.
- START: `rs485_txd`=0 for `BIT_CYCLES`, then go to DATA.
- DATA: shift out 8 bits LSB first, `BIT_CYCLES` each; a 3-bit bit counter wraps 7→0 on exit to STOP (or PARITY).
- STOP: `rs485_txd`=1 for `BIT_CYCLES`; pulse `tx_done` on the final cycle, then go to HOLD.
- HOLD: `tx_busy`=0 and `rs485_de` stays 1 for `DE_HOLD_CYCLES`, then `rs485_de`=0 and go to IDLE.
- `tx_en` in HOLD: latch the byte, set `tx_busy`=1, go straight to START (skip SETUP). `rs485_de` stays high with no glitch.
- `tx_en` while `tx_busy`=1 (SETUP…STOP): ignored. The byte is dropped and the current frame is unaffected.
- Baud counter: 16 bits, counts 0..`BIT_CYCLES`-1, reloads on every state/bit transition. No fractional accumulation.
- `rs485_txd` is a register output (glitch-free). It is 1 in IDLE, SETUP, and HOLD.
- Reset asserted mid-frame: all outputs return to reset values on the next clock edge. The partial frame is abandoned and `rs485_de` is dropped immediately.

## Timing
- `tx_en` sampled at edge 0 (IDLE): `tx_busy`/`rs485_de` high after edge 1; `rs485_txd` falls after edge 1+`DE_SETUP_CYCLES`.
- Frame length without parity = 10×`BIT_CYCLES`. `tx_done` is high during the last clock of that window.
- `tx_busy` falls on the clock after `tx_done`.
- `rs485_de` falls `DE_HOLD_CYCLES` clocks after `tx_busy` falls.
- Back-to-back bytes issued in HOLD: the next start bit begins the clock after `tx_en`, giving an inter-frame gap of ≥1 clock of idle-high.
- Throughput ceiling: one byte per (10×`BIT_CYCLES`+1) clocks.

## Configuration
- `RS485_TX_PARITY_EN` defined: adds the PARITY state between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for `BIT_CYCLES`. Frame = 11×`BIT_CYCLES`; `tx_done` moves to the end of STOP accordingly.
- Not defined: 8N1 only. No PARITY state or parity logic is synthesised.

## Test plan
Parameters: `CLK_FREQ`=50_000_000, `BAUD`=5_000_000 (`BIT_CYCLES`=10), `DE_SETUP_CYCLES`=4, `DE_HOLD_CYCLES`=8.
- Reset check: hold `reset_n`=0 for 5 clocks → `rs485_txd`=1, `rs485_de`=0, `tx_busy`=0, `tx_done`=0.
- Single byte: `tx_en` with 0x53 ("S") → `rs485_de` high 4 clocks before the start bit; line decodes to bits 0,1,1,0,0,1,0,1,0,1 over 100 clocks; `tx_done` is one pulse at clock 104 after acceptance; `rs485_de` low 8 clocks after `tx_busy` falls.
- Back-to-back: send 0x0D, then issue 0x0A in HOLD → `rs485_de` never deasserts; no second SETUP; both bytes decode correctly.
- Ignored strobe: pulse `tx_en` with 0xFF mid-DATA of 0x00 → line carries 0x00 only; exactly one `tx_done`.
- Reset mid-frame: assert reset during bit 3 of 0xA5 → next clock `rs485_txd`=1 and `rs485_de`=0. A following `tx_en` of 0x3C transmits cleanly.
- With `RS485_TX_PARITY_EN`: send 0x07 → parity bit 1; frame length 110 clocks. Send 0x03 → parity bit 0.

Source files
------------

// File: rtl/rs485_uart_tx_if.sv
// ----------------------------------------------------------------------------
// rs485_uart_tx_if
//
// This interface carries the byte handshake between the command-echo
// controller and the RS485 transmitter, plus the two line-side outputs.
//
// Signals:
//   tx_en      single-cycle strobe; tx_data is valid in the same cycle
//   tx_data    byte to send
//   tx_busy    high while a frame is in progress (back-pressure)
//   tx_done    one-cycle pulse on the last clock of the stop bit
//   rs485_txd  serial line, idle high
//   rs485_de   transceiver driver enable, active high
//
// Modports:
//   master  controller side (drives tx_en/tx_data)
//   slave   transmitter side (drives status and line outputs)
// ----------------------------------------------------------------------------
interface rs485_uart_tx_if;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       rs485_txd;
    logic       rs485_de;

    modport master (
        output tx_en, tx_data,
        input  tx_busy, tx_done, rs485_txd, rs485_de
    );

    modport slave (
        input  tx_en, tx_data,
        output tx_busy, tx_done, rs485_txd, rs485_de
    );
endinterface

// File: rtl/rs485_uart_tx.sv
// ----------------------------------------------------------------------------
// rs485_uart_tx
//
// Byte-serial RS485 transmitter. Accepts one byte per tx_en strobe,
// serialises it as UART 8N1 (LSB first) on rs485_txd, and drives the
// half-duplex transceiver enable rs485_de with setup and hold guard times.
// A byte offered during the hold guard restarts at the start bit directly,
// keeping rs485_de high across back-to-back frames.
//
// Ports:
//   clk      system clock
//   reset_n  synchronous, active-low reset
//   bus      rs485_uart_tx_if.slave (tx_en, tx_data, tx_busy, tx_done,
//            rs485_txd, rs485_de)
//
// Parameters:
//   CLK_FREQ, BAUD   bit period BIT_CYCLES = CLK_FREQ / BAUD (2..65535)
//   DE_SETUP_CYCLES  clocks of rs485_de before the start bit (>= 1)
//   DE_HOLD_CYCLES   clocks of rs485_de after the stop bit (>= 1)
//
// Build option:
//   RS485_TX_PARITY_EN  when defined, an even-parity bit is sent between
//                       the data bits and the stop bit (8E1).
// ----------------------------------------------------------------------------
module rs485_uart_tx #(
    parameter int unsigned CLK_FREQ        = 50_000_000,
    parameter int unsigned BAUD            = 115200,
    parameter int unsigned DE_SETUP_CYCLES = 16,
    parameter int unsigned DE_HOLD_CYCLES  = 16
) (
    input logic            clk,
    input logic            reset_n,
    rs485_uart_tx_if.slave bus
);
    localparam int unsigned BIT_CYCLES   = CLK_FREQ / BAUD;
    localparam logic [15:0] BIT_LAST     = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] BIT_PRE_LAST = 16'(BIT_CYCLES - 2);

    // One counter serves both guard phases, sized for the longer of the two.
    localparam int unsigned GUARD_MAX = (DE_SETUP_CYCLES > DE_HOLD_CYCLES) ?
                                        DE_SETUP_CYCLES : DE_HOLD_CYCLES;
    localparam int unsigned GUARD_W   = (GUARD_MAX > 1) ? $clog2(GUARD_MAX) : 1;
    localparam logic [GUARD_W-1:0] SETUP_LAST = GUARD_W'(DE_SETUP_CYCLES - 1);
    localparam logic [GUARD_W-1:0] HOLD_LAST  = GUARD_W'(DE_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_DATA,
`ifdef RS485_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          baud_cnt_q, baud_cnt_d;
    logic [GUARD_W-1:0]   guard_cnt_q, guard_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic                 de_q, de_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;
`ifdef RS485_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign bit_end = (baud_cnt_q == BIT_LAST);

    always_comb begin
        // NOTE: every _d gets a hold value first so no path through the case
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        guard_cnt_d = guard_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        txd_d       = txd_q;
        de_d        = de_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef RS485_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.tx_en) begin
                    shift_d     = bus.tx_data;
`ifdef RS485_TX_PARITY_EN
                    parity_d    = ^bus.tx_data;
`endif
                    busy_d      = 1'b1;
                    de_d        = 1'b1;
                    guard_cnt_d = '0;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (guard_cnt_q == SETUP_LAST) begin
                    guard_cnt_d = '0;
                    baud_cnt_d  = '0;
                    txd_d       = 1'b0;
                    state_d     = ST_START;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    txd_d      = shift_q[0];
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    // The 3-bit counter wraps 7 -> 0 as the last data bit ends.
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef RS485_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = ST_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        // Look one bit ahead so txd stays a plain register.
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end

`ifdef RS485_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    txd_d      = 1'b1;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_d  = '0;
                    guard_cnt_d = '0;
                    busy_d      = 1'b0;
                    state_d     = ST_HOLD;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                    // Registered pulse: raise it one clock early so it lands
                    // on the final clock of the stop bit.
                    done_d     = (baud_cnt_q == BIT_PRE_LAST);
                end
            end

            ST_HOLD: begin
                if (bus.tx_en) begin
                    // Driver is already enabled, so go straight to the start bit.
                    shift_d     = bus.tx_data;
`ifdef RS485_TX_PARITY_EN
                    parity_d    = ^bus.tx_data;
`endif
                    busy_d      = 1'b1;
                    guard_cnt_d = '0;
                    baud_cnt_d  = '0;
                    txd_d       = 1'b0;
                    state_d     = ST_START;
                end else if (guard_cnt_q == HOLD_LAST) begin
                    guard_cnt_d = '0;
                    de_d        = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                baud_cnt_d  = '0;
                guard_cnt_d = '0;
                bit_cnt_d   = '0;
                txd_d       = 1'b1;
                de_d        = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments; reset is
    // sampled on the clock edge (synchronous), so it takes effect on the
    // next edge and drops rs485_de at once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            baud_cnt_q  <= '0;
            guard_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            txd_q       <= 1'b1;
            de_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RS485_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            de_q        <= de_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef RS485_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.rs485_txd = txd_q;
    assign bus.rs485_de  = de_q;
    assign bus.tx_busy   = busy_q;
    assign bus.tx_done   = done_q;

endmodule

// File: tb/tb_rs485_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_rs485_uart_tx
//
// Self-checking bench for rs485_uart_tx with BIT_CYCLES=10, setup 4, hold 8.
// A timeline model predicts the four outputs every clock from the time a
// byte was accepted; a table of hand-derived points covers one 0x53 frame;
// hand sequences cover back-to-back, ignored strobe, mid-frame reset and
// (with RS485_TX_PARITY_EN) the parity bit. A small UART receiver decodes
// the line independently.
// ----------------------------------------------------------------------------
module tb_rs485_uart_tx;
    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 5_000_000;
    localparam int SETUP = 4;
    localparam int HOLD  = 8;
    localparam int B     = 10;
`ifdef RS485_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic NINTH_53 = 1'b0;   // even parity of 0x53 (four ones)
`else
    localparam int NBITS = 10;
    localparam logic NINTH_53 = 1'b1;   // stop bit
`endif
    localparam int FB = NBITS * B;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    rs485_uart_tx_if bus ();

    rs485_uart_tx #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD           (BAUD),
        .DE_SETUP_CYCLES(SETUP),
        .DE_HOLD_CYCLES (HOLD)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // ---------------- timeline reference model ----------------
    typedef struct packed {
        logic txd;
        logic de;
        logic busy;
        logic done;
    } outs_t;

    bit         have_frame = 1'b0;
    int         t0 = 0;          // edge after which the start bit is on the line
    logic [7:0] fdata = 8'h00;

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef RS485_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    function automatic outs_t model_at(input int e);
        outs_t o;
        int j;
        o = 4'b1000;
        if (have_frame) begin
            j = e - t0;
            if (j < FB + HOLD) begin
                o.de   = 1'b1;
                o.busy = (j < FB);
                o.done = (j == FB - 1);
                if (j >= 0 && j < FB) o.txd = frame_bit(fdata, j / B);
            end
        end
        return o;
    endfunction

    function automatic outs_t outs_now();
        outs_t o;
        o = {bus.rs485_txd, bus.rs485_de, bus.tx_busy, bus.tx_done};
        return o;
    endfunction

    // One clock: drive inputs, let the edge happen, update the model, and
    // compare all outputs on the falling edge.
    task automatic step(input logic rst_in, input logic en, input logic [7:0] d);
        outs_t prev;
        outs_t exp;
        reset_n     = rst_in;
        bus.tx_en   = en;
        bus.tx_data = d;
        prev = model_at(edge_n);
        @(posedge clk);
        edge_n++;
        if (!rst_in) begin
            have_frame = 1'b0;
        end else if (en && !prev.busy) begin
            have_frame = 1'b1;
            fdata      = d;
            // Driver already on (hold guard) -> start bit next; else setup first.
            t0 = prev.de ? edge_n : edge_n + SETUP;
        end
        @(negedge clk);
        exp = model_at(edge_n);
        check("outputs{txd,de,busy,done}", 32'(outs_now()), 32'(exp));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((bus.tx_busy !== 1'b0 || bus.rs485_de !== 1'b0) && n < 400) begin
            step(1'b1, 1'b0, 8'h00);
            n++;
        end
        check({name, "_idle_timeout"}, 32'(n < 400), 32'd1);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
    endtask

    // ---------------- line monitors ----------------
    logic [7:0] rx_q[$];
    logic       rx_par_q[$];
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_ferr = 0;
    int         done_cnt = 0;
    int         de_fall_cnt = 0;
    logic       de_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            rx_active <= 1'b0;
            rx_cnt    <= 0;
        end else if (!rx_active) begin
            if (bus.rs485_txd === 1'b0) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % B == B / 2) begin
                if (rx_cnt / B >= 1 && rx_cnt / B <= 8)
                    rx_sh <= {bus.rs485_txd, rx_sh[7:1]};
`ifdef RS485_TX_PARITY_EN
                if (rx_cnt / B == 9)
                    rx_par_q.push_back(bus.rs485_txd);
`endif
                if (rx_cnt / B == NBITS - 1) begin
                    rx_q.push_back(rx_sh);
                    if (bus.rs485_txd !== 1'b1) rx_ferr <= rx_ferr + 1;
                    rx_active <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        de_prev <= bus.rs485_de;
        if (bus.tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (de_prev === 1'b1 && bus.rs485_de === 1'b0) de_fall_cnt <= de_fall_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    typedef struct {
        int         k;
        logic [3:0] exp;   // {txd, de, busy, done}
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   rx_before;
    int   done_before;
    int   fall_before;
    int   n;

    initial begin
        bus.tx_en   = 1'b0;
        bus.tx_data = 8'h00;

        // Points of the 0x53 frame, k = edges counted from the strobe cycle.
        vecs.push_back('{1,       4'b1110, "accept_de_busy"});
        vecs.push_back('{4,       4'b1110, "setup_last"});
        vecs.push_back('{5,       4'b0110, "start_first"});
        vecs.push_back('{14,      4'b0110, "start_last"});
        vecs.push_back('{15,      4'b1110, "bit0"});
        vecs.push_back('{25,      4'b1110, "bit1"});
        vecs.push_back('{35,      4'b0110, "bit2"});
        vecs.push_back('{45,      4'b0110, "bit3"});
        vecs.push_back('{55,      4'b1110, "bit4"});
        vecs.push_back('{65,      4'b0110, "bit5"});
        vecs.push_back('{75,      4'b1110, "bit6"});
        vecs.push_back('{85,      4'b0110, "bit7"});
        vecs.push_back('{95,      {NINTH_53, 3'b110}, "ninth_bit"});
        vecs.push_back('{3 + FB,  4'b1110, "done_before"});
        vecs.push_back('{4 + FB,  4'b1111, "done_pulse"});
        vecs.push_back('{5 + FB,  4'b1100, "busy_fall"});
        vecs.push_back('{12 + FB, 4'b1100, "hold_last"});
        vecs.push_back('{13 + FB, 4'b1000, "de_fall"});

        // Reset: five clocks low.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
        check("reset_state", 32'(outs_now()), 32'(4'b1000));
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);

        // Single byte 0x53, table-driven.
        rx_before   = rx_q.size();
        done_before = done_cnt;
        for (int k = 1; k <= FB + 20; k++) begin
            step(1'b1, k == 1, 8'h53);
            foreach (vecs[i])
                if (vecs[i].k == k)
                    check(vecs[i].name, 32'(outs_now()), 32'(vecs[i].exp));
        end
        check("single_rx_count", 32'(rx_q.size() - rx_before), 32'd1);
        if (rx_q.size() > rx_before) check("single_rx_byte", 32'(rx_q[rx_before]), 32'h53);
        check("single_done_count", 32'(done_cnt - done_before), 32'd1);

        // Back-to-back: 0x0D then 0x0A issued in the hold guard.
        rx_before   = rx_q.size();
        done_before = done_cnt;
        fall_before = de_fall_cnt;
        step(1'b1, 1'b1, 8'h0D);
        n = 0;
        while (bus.tx_busy !== 1'b0 && n < 300) begin
            step(1'b1, 1'b0, 8'h00);
            n++;
        end
        check("b2b_wait_busy_low", 32'(n < 300), 32'd1);
        check("b2b_in_hold_de", 32'(bus.rs485_de), 32'd1);
        step(1'b1, 1'b1, 8'h0A);
        check("b2b_no_setup_start", 32'(bus.rs485_txd), 32'd0);
        wait_idle("b2b");
        check("b2b_de_falls_once", 32'(de_fall_cnt - fall_before), 32'd1);
        check("b2b_rx_count", 32'(rx_q.size() - rx_before), 32'd2);
        if (rx_q.size() >= rx_before + 2) begin
            check("b2b_rx_byte0", 32'(rx_q[rx_before]), 32'h0D);
            check("b2b_rx_byte1", 32'(rx_q[rx_before + 1]), 32'h0A);
        end
        check("b2b_done_count", 32'(done_cnt - done_before), 32'd2);

        // Ignored strobe: 0xFF offered during the data bits of 0x00.
        rx_before   = rx_q.size();
        done_before = done_cnt;
        step(1'b1, 1'b1, 8'h00);
        for (int k = 2; k <= 45; k++) step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hFF);
        wait_idle("ignored");
        check("ignored_rx_count", 32'(rx_q.size() - rx_before), 32'd1);
        if (rx_q.size() > rx_before) check("ignored_rx_byte", 32'(rx_q[rx_before]), 32'h00);
        check("ignored_done_count", 32'(done_cnt - done_before), 32'd1);

        // Reset during bit 3 of 0xA5, then 0x3C must go out cleanly.
        step(1'b1, 1'b1, 8'hA5);
        for (int k = 2; k <= 48; k++) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("reset_mid_next_clock", 32'(outs_now()), 32'(4'b1000));
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        rx_before = rx_q.size();
        step(1'b1, 1'b1, 8'h3C);
        wait_idle("reset_recover");
        check("reset_recover_rx_count", 32'(rx_q.size() - rx_before), 32'd1);
        if (rx_q.size() > rx_before) check("reset_recover_rx_byte", 32'(rx_q[rx_before]), 32'h3C);

`ifdef RS485_TX_PARITY_EN
        // Parity bit: 0x07 has three ones -> 1; 0x03 has two -> 0.
        rx_before = rx_par_q.size();
        step(1'b1, 1'b1, 8'h07);
        wait_idle("parity_07");
        step(1'b1, 1'b1, 8'h03);
        wait_idle("parity_03");
        check("parity_count", 32'(rx_par_q.size() - rx_before), 32'd2);
        if (rx_par_q.size() >= rx_before + 2) begin
            check("parity_07_bit", 32'(rx_par_q[rx_before]), 32'd1);
            check("parity_03_bit", 32'(rx_par_q[rx_before + 1]), 32'd0);
        end
`endif

        check("rx_framing_errors", 32'(rx_ferr), 32'd0);

        // Random strobes, data and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic e;
            logic [7:0] d;
            r = ($urandom_range(0, 399) != 0);
            e = (bus.tx_busy === 1'b1) ? ($urandom_range(0, 39) == 0)
                                       : ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            step(r, e, d);
        end
        wait_idle("random_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
